// File: rtl/frog_move_if.sv
// Button, frame-timing and frog-position signals between the board/video side
// and the frog move controller.
interface frog_move_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       frame_tick;
   logic [9:0] frog_x;
   logic [9:0] frog_y;
   logic       busy;
   logic       goal;
   logic [7:0] hop_count;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, frame_tick,
      input  frog_x, frog_y, busy, goal, hop_count
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, frame_tick,
      output frog_x, frog_y, busy, goal, hop_count
   );
endinterface

// File: rtl/frog_move_controller.sv
// Debounces four buttons and commits one grid hop per press on the vblank
// frame_tick, with edge clamping, a post-hop cooldown and goal-row respawn.
//
// state      | meaning
// S_IDLE     | waiting for a debounced press
// S_PENDING  | direction latched, waiting for frame_tick to commit the hop
// S_COOLDOWN | hop done, counting frame_ticks before accepting a new press
module frog_move_controller #(
   parameter int GRID_SIZE       = 32,
   parameter int H_CELLS         = 20,
   parameter int V_CELLS         = 15,
   parameter int START_X         = 288,
   parameter int START_Y         = 448,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int COOLDOWN_FRAMES = 8
) (
   input logic        clk,
   input logic        reset,
   frog_move_if.slave bus
);

   localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam int CD_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
   localparam logic [10:0]     GRID11  = 11'(GRID_SIZE);
   localparam logic [10:0]     MAX_X11 = 11'((H_CELLS - 1) * GRID_SIZE);
   localparam logic [10:0]     MAX_Y11 = 11'((V_CELLS - 1) * GRID_SIZE);

   typedef enum logic [1:0] {S_IDLE, S_PENDING, S_COOLDOWN} state_t;
   typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

   // bit order everywhere: 0 up, 1 down, 2 left, 3 right
   logic [3:0]      btn_raw;
   logic [3:0]      sync1, sync2, deb, deb_prev, press;
   logic [DB_W-1:0] db_cnt [4];

   assign btn_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1    <= '0;
         sync2    <= '0;
         deb      <= '0;
         deb_prev <= '0;
         press    <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= DB_LOAD;
      end else begin
         sync1    <= btn_raw;
         sync2    <= sync1;
         deb_prev <= deb;
         press    <= deb & ~deb_prev;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= DB_LOAD;
            end else if (db_cnt[i] == '0) begin
               deb[i]    <= sync2[i];
               db_cnt[i] <= DB_LOAD;
            end else begin
               db_cnt[i] <= db_cnt[i] - 1'b1;
            end
         end
      end
   end

   logic any_press;
   dir_t press_dir;

   always_comb begin
      any_press = |press;
      press_dir = D_RIGHT;
      if (press[0])      press_dir = D_UP;
      else if (press[1]) press_dir = D_DOWN;
      else if (press[2]) press_dir = D_LEFT;
   end

   state_t         state;
   dir_t           dir_q;
   logic [CD_W-1:0] cd_cnt;
   logic [9:0]     frog_x_q, frog_y_q;
   logic [7:0]     hop_q;
   logic           busy_q, goal_q;
   logic [10:0]    tgt_x, tgt_y;
   logic           in_grid, at_goal;

   // Upward/leftward underflow wraps to a large 11-bit value and fails the max check.
   always_comb begin
      tgt_x = {1'b0, frog_x_q};
      tgt_y = {1'b0, frog_y_q};
      unique case (dir_q)
         D_UP:    tgt_y = {1'b0, frog_y_q} - GRID11;
         D_DOWN:  tgt_y = {1'b0, frog_y_q} + GRID11;
         D_LEFT:  tgt_x = {1'b0, frog_x_q} - GRID11;
         D_RIGHT: tgt_x = {1'b0, frog_x_q} + GRID11;
         default: ;
      endcase
      in_grid = (tgt_x <= MAX_X11) && (tgt_y <= MAX_Y11);
      at_goal = in_grid && (tgt_y == 11'd0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         dir_q    <= D_UP;
         cd_cnt   <= '0;
         frog_x_q <= 10'(START_X);
         frog_y_q <= 10'(START_Y);
         hop_q    <= '0;
         busy_q   <= 1'b0;
         goal_q   <= 1'b0;
      end else begin
         goal_q <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (any_press) begin
                  dir_q  <= press_dir;
                  busy_q <= 1'b1;
                  state  <= S_PENDING;
               end
            end
            S_PENDING: begin
               if (bus.frame_tick) begin
                  if (at_goal) begin
                     frog_x_q <= 10'(START_X);
                     frog_y_q <= 10'(START_Y);
                     goal_q   <= 1'b1;
                     hop_q    <= hop_q + 8'd1;
                  end else if (in_grid) begin
                     frog_x_q <= tgt_x[9:0];
                     frog_y_q <= tgt_y[9:0];
                     hop_q    <= hop_q + 8'd1;
                  end
                  cd_cnt <= CD_LOAD;
                  state  <= S_COOLDOWN;
               end
            end
            S_COOLDOWN: begin
               if (cd_cnt == '0 || (bus.frame_tick && cd_cnt == CD_W'(1))) begin
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end else if (bus.frame_tick) begin
                  cd_cnt <= cd_cnt - 1'b1;
               end
            end
            default: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.frog_x    = frog_x_q;
   assign bus.frog_y    = frog_y_q;
   assign bus.busy      = busy_q;
   assign bus.goal      = goal_q;
   assign bus.hop_count = hop_q;

endmodule

// File: tb/tb_frog_move_controller.sv
// Directed plus randomized hop sequences checked against a grid-cell model of
// the frog (column/row arithmetic, respawn on reaching row 0).
module tb_frog_move_controller;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   int   m_col, m_row, m_hops;
   bit   m_goal;

   frog_move_if bus ();

   frog_move_controller #(
      .GRID_SIZE      (32),
      .H_CELLS        (20),
      .V_CELLS        (15),
      .START_X        (288),
      .START_Y        (448),
      .DEBOUNCE_CYCLES(4),
      .COOLDOWN_FRAMES(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_buttons(input logic [3:0] mask);
      bus.btn_up    = mask[0];
      bus.btn_down  = mask[1];
      bus.btn_left  = mask[2];
      bus.btn_right = mask[3];
   endtask

   task automatic tick();
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
   endtask

   task automatic model_reset();
      m_col  = 9;
      m_row  = 14;
      m_hops = 0;
      m_goal = 1'b0;
   endtask

   // Highest-priority pressed direction moves one cell; off-grid is ignored;
   // landing on row 0 scores and respawns at the start cell.
   task automatic model_hop(input logic [3:0] mask);
      int nc, nr;
      nc = m_col;
      nr = m_row;
      m_goal = 1'b0;
      if (mask[0])      nr = nr - 1;
      else if (mask[1]) nr = nr + 1;
      else if (mask[2]) nc = nc - 1;
      else              nc = nc + 1;
      if (nc >= 0 && nc < 20 && nr >= 0 && nr < 15) begin
         m_hops = (m_hops + 1) % 256;
         if (nr == 0) begin
            m_goal = 1'b1;
            m_col  = 9;
            m_row  = 14;
         end else begin
            m_col = nc;
            m_row = nr;
         end
      end
   endtask

   task automatic check_pos(input string tag);
      check({tag, "_x"},    32'(bus.frog_x),    32'(m_col * 32));
      check({tag, "_y"},    32'(bus.frog_y),    32'(m_row * 32));
      check({tag, "_hops"}, 32'(bus.hop_count), 32'(m_hops));
   endtask

   task automatic hold_press(input logic [3:0] mask);
      set_buttons(mask);
      repeat (10) cyc();
      set_buttons(4'b0000);
      repeat (8) cyc();
   endtask

   task automatic commit(input string tag, input logic [3:0] mask);
      hold_press(mask);
      check({tag, "_busy_pending"}, 32'(bus.busy), 32'd1);
      tick();
      model_hop(mask);
      check_pos(tag);
      check({tag, "_goal"}, 32'(bus.goal), 32'(m_goal));
      cyc();
      check({tag, "_goal_end"}, 32'(bus.goal), 32'd0);
   endtask

   task automatic finish_cooldown(input string tag);
      tick();
      check({tag, "_busy_cd1"}, 32'(bus.busy), 32'd1);
      tick();
      check({tag, "_busy_cd2"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic do_hop(input string tag, input logic [3:0] mask);
      commit(tag, mask);
      finish_cooldown(tag);
   endtask

   initial begin
      logic [3:0] mask;
      int guard;
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      bus.frame_tick = 1'b0;
      set_buttons(4'b0000);
      model_reset();
      repeat (3) cyc();
      reset = 1'b0;
      cyc();
      check_pos("reset");
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_goal", 32'(bus.goal), 32'd0);

      // Up held: press appears after DEBOUNCE+3 cycles; a tick in the press cycle is not used.
      bus.btn_up = 1'b1;
      repeat (7) cyc();
      check("latency_busy_before", 32'(bus.busy), 32'd0);
      tick();
      check("latency_busy_after", 32'(bus.busy), 32'd1);
      check("same_cycle_tick_y", 32'(bus.frog_y), 32'd448);
      repeat (2) cyc();
      bus.btn_up = 1'b0;
      repeat (8) cyc();
      tick();
      model_hop(4'b0001);
      check_pos("up1");
      check("up1_busy", 32'(bus.busy), 32'd1);
      finish_cooldown("up1");

      // Short glitch never reaches the debounced level.
      bus.btn_left = 1'b1;
      repeat (3) cyc();
      bus.btn_left = 1'b0;
      repeat (10) cyc();
      check("glitch_busy", 32'(bus.busy), 32'd0);
      tick();
      check_pos("glitch");

      for (int i = 0; i < 12; i++) begin
         mask = 4'($urandom_range(1, 15));
         repeat ($urandom_range(0, 5)) cyc();
         if ($urandom_range(0, 1) == 1) tick();
         do_hop("rand", mask);
      end

      guard = 0;
      while (m_col < 19 && guard < 25) begin
         do_hop("to_right", 4'b1000);
         guard++;
      end
      do_hop("right_edge", 4'b1000);

      do_hop("up_and_right", 4'b1001);

      guard = 0;
      while (m_row > 1 && guard < 20) begin
         do_hop("to_top", 4'b0001);
         guard++;
      end
      do_hop("goal", 4'b0001);

      // A press during cooldown is dropped, not queued.
      commit("cd_setup", 4'b1000);
      hold_press(4'b0100);
      finish_cooldown("cd_drop");
      repeat (4) cyc();
      tick();
      check_pos("cd_drop_after");
      check("cd_drop_busy", 32'(bus.busy), 32'd0);

      // Reset while PENDING aborts the hop immediately.
      bus.btn_up = 1'b1;
      repeat (10) cyc();
      check("pend_busy", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      #1;
      model_reset();
      check_pos("mid_reset");
      check("mid_reset_busy", 32'(bus.busy), 32'd0);
      check("mid_reset_goal", 32'(bus.goal), 32'd0);
      bus.btn_up = 1'b0;
      repeat (2) cyc();
      reset = 1'b0;
      repeat (10) cyc();
      tick();
      check_pos("post_reset_idle");
      do_hop("post_reset", 4'b0010);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
